score_read_sequencer: RTL
=========================

// Module: score_read_sequencer
// PURPOSE
// - Upstream feeder of the score-RAM output manager in the NW score-matrix datapath.
// - For one matrix cell (i,j), reads the three neighbour scores from score RAM: diag (i-1,j-1), up (i-1,j), left (i,j-1).
// - Drives the RAM read port and the manager's en_read/count/signal strobes, then reports completion to the cell controller.
// PARAMETERS
// - N       default 128  sequence length; matrix is (N+1)x(N+1), row-major, row stride N+1
// - IDX_W   default 8    width of i/j indices (must hold N)
// - ADDR_W  default 15   RAM address width (must hold (N+1)^2-1)
// - RD_LAT  default 1    RAM read latency in cycles, >=1
// PORTS
// - clk       in   1       clock, all logic on posedge
// - rst       in   1       synchronous reset, active-low (asserted when 0)
// - start     in   1       request to fetch neighbours of (i,j); sampled only in IDLE
// - i         in   IDX_W   cell row, captured on accepted start
// - j         in   IDX_W   cell column, captured on accepted start
// - busy      out  1       high from accepted start until done/err cycle inclusive
// - done      out  1       1-cycle pulse: diag/up/left now valid at manager outputs
// - err       out  1       1-cycle pulse: (i,j) rejected, no RAM access made
// - ram_re    out  1       RAM read enable
// - ram_addr  out  ADDR_W  RAM read address
// - en_read   out  1       to manager: ram_data valid this cycle, store at count
// - count     out  2       to manager: buffer slot 0=diag 1=up 2=left
// - signal    out  1       to manager: buffer complete, load outputs
// BEHAVIOUR
// - Reset (rst==0 at edge): state IDLE, every output 0, read-tag pipeline cleared; applies mid-operation, abandoned reads never produce en_read.
// - FSM: IDLE -> ISSUE (3 cyc) -> DRAIN (RD_LAT cyc overlapped) -> PRESENT (1 cyc) -> DONE (1 cyc) -> IDLE; IDLE -> ERR (1 cyc) -> IDLE.
// - Accept: start=1 in IDLE latches i,j; busy=1 next cycle. start while busy ignored, not queued.
// - Reject: i==0, j==0, i>N or j>N -> ERR: err=1, busy=1 that cycle, ram_re/en_read never asserted.
// - Timing, accept at edge T0 (cycle 0): ram_re=1 in cycles 1,2,3.
//   - cycle 1 addr=(i-1)(N+1)+(j-1) tag 0; cycle 2 addr=(i-1)(N+1)+j tag 1; cycle 3 addr=i(N+1)+(j-1) tag 2.
// - Tag pipeline: RD_LAT-deep shift of {valid,tag}; en_read=1,count=tag in cycles 1+RD_LAT..3+RD_LAT.
// - signal=1 exactly in cycle 4+RD_LAT (one after last en_read); done=1 in cycle 5+RD_LAT; busy falls after done.
// - count holds last value when en_read=0; ram_addr=0 when ram_re=0.
// - Arithmetic: row base i*(N+1) computed full-width then truncated to ADDR_W; no wrap for legal (i,j) given parameter rules.
// - Back-to-back: start high in cycle after done accepted (IDLE reached); min cell period 6+RD_LAT cycles.
// - Simultaneous start and rst==0: reset wins.
// CONFIGURATION
// - SRS_CELL_CNT_EN defined: extra port cell_cnt out 16; +1 on each done, saturates at 16'hFFFF, not on err; reset 0.
// - SRS_CELL_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING (N=4, RD_LAT=1 unless noted)
// - Reset: hold rst=0 3 cycles with start=1 -> all outputs 0, busy stays 0.
// - Nominal i=2,j=3: ram_addr 7,8,12 cycles 1-3; en_read count 0,1,2 cycles 2-4; signal cycle 5; done cycle 6.
// - Boundary i=0,j=2 and i=5,j=1 -> err pulse cycle 1, ram_re never 1, done never 1.
// - RD_LAT=3, i=1,j=1: addrs 0,1,5; en_read cycles 4-6; signal 7; done 8.
// - Reset mid-op: rst=0 in cycle 2 of nominal cell -> no en_read/signal/done after, next start runs clean.
// - start held high across cell, then SRS_CELL_CNT_EN with 2 good cells + 1 err -> second cell starts cycle after done; cell_cnt=2.

Source files
------------

// File: rtl/score_read_sequencer.sv
// score_read_sequencer: fetches the diag/up/left neighbour scores of cell (i,j)
// from score RAM and strobes them into the score-RAM output manager.
//
// Ports:
//   clk, rst (sync, active-low)
//   start, i, j                -> cell request, sampled only when idle
//   busy, done, err            -> status toward the cell controller
//   ram_re, ram_addr           -> score-RAM read port
//   en_read, count, signal     -> output-manager strobes
//   cell_cnt (SRS_CELL_CNT_EN) -> saturating count of completed cells
//
// Optional feature macro: SRS_CELL_CNT_EN adds the cell_cnt port/counter.
module score_read_sequencer #(
  parameter int N      = 128,
  parameter int IDX_W  = 8,
  parameter int ADDR_W = 15,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  i,
  input  logic [IDX_W-1:0]  j,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              en_read,
  output logic [1:0]        count,
  output logic              signal
`ifdef SRS_CELL_CNT_EN
  ,
  output logic [15:0]       cell_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_PRESENT,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q;
  logic [IDX_W-1:0]    i_q;
  logic [IDX_W-1:0]    j_q;
  logic [1:0]          tag_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic                ram_re_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                signal_q;
  logic [1:0]          count_q;
  logic [RD_LAT-1:0]   pv_q;
  logic [2*RD_LAT-1:0] pt_q;
`ifdef SRS_CELL_CNT_EN
  logic [15:0]         cnt_q;
`endif

  // Stage 0 is the read being issued this cycle; stage RD_LAT is the
  // read whose data the RAM presents this cycle.
  logic [RD_LAT:0]     pv_d;
  logic [2*RD_LAT+1:0] pt_d;
  logic                last_v;
  logic [1:0]          last_t;
  logic                bad_ij;

  assign pv_d   = {pv_q, ram_re_q};
  assign pt_d   = {pt_q, tag_q};
  assign last_v = pv_d[RD_LAT];
  assign last_t = pt_d[2*RD_LAT +: 2];

  assign bad_ij = (i == '0) || (j == '0) ||
                  (32'(i) > 32'(N)) || (32'(j) > 32'(N));

  // sel 0=diag (i-1,j-1), 1=up (i-1,j), 2=left (i,j-1)
  function automatic logic [ADDR_W-1:0] addr_of(
    input logic [IDX_W-1:0] ri,
    input logic [IDX_W-1:0] cj,
    input logic [1:0]       sel
  );
    logic [31:0] r;
    logic [31:0] c;
    r = (sel == 2'd2) ? 32'(ri) : 32'(ri) - 32'd1;
    c = (sel == 2'd1) ? 32'(cj) : 32'(cj) - 32'd1;
    return ADDR_W'(r * 32'(N + 1) + c);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      pv_q    <= '0;
      pt_q    <= '0;
      count_q <= '0;
    end else begin
      pv_q <= pv_d[RD_LAT-1:0];
      pt_q <= pt_d[2*RD_LAT-1:0];
      // count follows the tag entering the last stage, holds otherwise
      if (pv_d[RD_LAT-1])
        count_q <= pt_d[2*(RD_LAT-1) +: 2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      j_q      <= '0;
      tag_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ram_re_q <= 1'b0;
      addr_q   <= '0;
      signal_q <= 1'b0;
`ifdef SRS_CELL_CNT_EN
      cnt_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (bad_ij) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else begin
              state_q  <= S_ISSUE;
              i_q      <= i;
              j_q      <= j;
              tag_q    <= 2'd0;
              ram_re_q <= 1'b1;
              addr_q   <= addr_of(i, j, 2'd0);
            end
          end
        end
        S_ISSUE: begin
          if (tag_q == 2'd2) begin
            state_q  <= S_DRAIN;
            ram_re_q <= 1'b0;
            addr_q   <= '0;
          end else begin
            tag_q  <= tag_q + 2'd1;
            addr_q <= addr_of(i_q, j_q, tag_q + 2'd1);
          end
        end
        S_DRAIN: begin
          // left-neighbour data lands this cycle: buffer complete next
          if (last_v && last_t == 2'd2) begin
            state_q  <= S_PRESENT;
            signal_q <= 1'b1;
          end
        end
        S_PRESENT: begin
          state_q  <= S_DONE;
          signal_q <= 1'b0;
          done_q   <= 1'b1;
`ifdef SRS_CELL_CNT_EN
          if (cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 16'd1;
`endif
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        S_ERR: begin
          state_q <= S_IDLE;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign ram_re   = ram_re_q;
  assign ram_addr = addr_q;
  assign en_read  = last_v;
  assign count    = count_q;
  assign signal   = signal_q;
`ifdef SRS_CELL_CNT_EN
  assign cell_cnt = cnt_q;
`endif

endmodule
